// File: rtl/monopix_ro_seq.sv
// Readout sequencer for the Monopix chip. It freezes the hit buffers, then reads and shifts each serial
// hit word into a first-word-fall-through output FIFO. Optional macro: MONOPIX_RO_GRAY_DEC_EN.
module monopix_ro_seq #(
    parameter int unsigned HIT_BITS        = 26,
    parameter int unsigned FREEZE_DLY      = 2,
    parameter int unsigned DEPTH_LOG2      = 3,
    parameter logic [3:0]  DATA_IDENTIFIER = 4'b0001
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ENABLE,
    input  logic        TOKEN,
    input  logic        DATA,
    output logic        FREEZE,
    output logic        READ,
    output logic        SHIFT_EN,
    input  logic        FIFO_READ,
    output logic        FIFO_EMPTY,
    output logic [31:0] FIFO_DATA,
    output logic [7:0]  LOST_CNT
);
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

    typedef enum logic [2:0] {IDLE, FRZ_WAIT, READ_P, SHIFT, STORE, UNFRZ} state_t;

    state_t                state, state_nxt;
    logic [4:0]            cnt;
    logic [HIT_BITS-1:0]   hit_sr;
    logic [HIT_BITS-1:0]   hit_out;
    logic [31:0]           push_word;
    logic                  go, push, pop, accept, fifo_full;
    logic [DEPTH_LOG2:0]   wr_ptr, rd_ptr;
    logic [31:0]           mem [DEPTH];

    assign go = TOKEN & ENABLE;

    always_comb begin
        state_nxt = state;
        FREEZE    = 1'b0;
        READ      = 1'b0;
        SHIFT_EN  = 1'b0;
        push      = 1'b0;
        case (state)
            IDLE:     if (go) state_nxt = FRZ_WAIT;
            FRZ_WAIT: begin
                FREEZE = 1'b1;
                if (cnt == 5'(FREEZE_DLY - 1)) state_nxt = READ_P;
            end
            READ_P: begin
                FREEZE    = 1'b1;
                READ      = 1'b1;
                state_nxt = SHIFT;
            end
            SHIFT: begin
                FREEZE   = 1'b1;
                SHIFT_EN = 1'b1;
                if (cnt == 5'(HIT_BITS - 1)) state_nxt = STORE;
            end
            STORE: begin
                FREEZE    = 1'b1;
                push      = 1'b1;
                state_nxt = go ? READ_P : UNFRZ;
            end
            UNFRZ:    state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // cnt measures time spent in the current state; it restarts on every state change
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            hit_sr <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? '0 : cnt + 5'd1;
            if (state == SHIFT) hit_sr <= {hit_sr[HIT_BITS-2:0], DATA};
        end
    end

`ifdef MONOPIX_RO_GRAY_DEC_EN
    // Timestamp byte arrives gray-coded; each binary bit is the xor of all gray bits at or above it
    always_comb begin
        hit_out = hit_sr;
        for (int unsigned i = 0; i < 7; i++) begin
            hit_out[6-i] = hit_out[7-i] ^ hit_sr[6-i];
        end
    end
`else
    assign hit_out = hit_sr;
`endif

    assign push_word  = {DATA_IDENTIFIER, 28'(hit_out)};

    assign FIFO_EMPTY = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                        (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    assign pop        = FIFO_READ & ~FIFO_EMPTY;
    // A full FIFO still takes the word when a pop frees the slot in the same cycle
    assign accept     = push & (~fifo_full | FIFO_READ);
    assign FIFO_DATA  = mem[rd_ptr[DEPTH_LOG2-1:0]];

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            LOST_CNT <= '0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + 1'b1;
            if (pop)    rd_ptr <= rd_ptr + 1'b1;
            if (push && !accept && LOST_CNT != 8'hFF) LOST_CNT <= LOST_CNT + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (accept) mem[wr_ptr[DEPTH_LOG2-1:0]] <= push_word;
    end

endmodule

// File: tb/tb_monopix_ro_seq.sv
// Self-checking bench for monopix_ro_seq: a cycle-timeline model plus directed literal checks.
// Honours MONOPIX_RO_GRAY_DEC_EN so that it matches the matching RTL build.
module tb_monopix_ro_seq;
    localparam int HB    = 26;
    localparam int FD    = 2;
    localparam int DEPTH = 8;
    localparam int WPER  = HB + 2;

`ifdef MONOPIX_RO_GRAY_DEC_EN
    localparam logic [31:0] W1 = 32'h12AAAACC;
    localparam logic [31:0] WG = 32'h10000080;
    localparam logic [31:0] WF = 32'h13FFFFAA;
`else
    localparam logic [31:0] W1 = 32'h12AAAAAA;
    localparam logic [31:0] WG = 32'h100000C0;
    localparam logic [31:0] WF = 32'h13FFFFFF;
`endif

    logic        CLK = 0, RST = 1, ENABLE = 0, TOKEN = 0, DATA = 0, FIFO_READ = 0;
    logic        FREEZE, READ, SHIFT_EN, FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic [7:0]  LOST_CNT;
    int          checks = 0, errors = 0;

    always #5 CLK = ~CLK;

    monopix_ro_seq #(
        .HIT_BITS(HB), .FREEZE_DLY(FD), .DEPTH_LOG2(3), .DATA_IDENTIFIER(4'b0001)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .TOKEN(TOKEN), .DATA(DATA),
        .FREEZE(FREEZE), .READ(READ), .SHIFT_EN(SHIFT_EN),
        .FIFO_READ(FIFO_READ), .FIFO_EMPTY(FIFO_EMPTY), .FIFO_DATA(FIFO_DATA),
        .LOST_CNT(LOST_CNT)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: m_age counts cycles since FREEZE rose (-1 when idle); m_wstart is the age of the current READ.
    int          m_age = -1, m_wstart = 0, m_started = 0, m_lost = 0;
    bit          m_unfrz = 0;
    logic [31:0] m_q[$];
    logic [27:0] m_bits = '0;
    logic [25:0] src_list[$];
    bit          cmp_on = 0;

    function automatic bit m_busy();
        return m_age >= 0 && !m_unfrz;
    endfunction
    function automatic bit m_read();
        return m_busy() && m_age == m_wstart;
    endfunction
    function automatic int m_shift_idx();
        if (m_busy() && m_age > m_wstart && m_age <= m_wstart + HB) return m_age - m_wstart - 1;
        return -1;
    endfunction
    function automatic bit m_store();
        return m_busy() && m_age == m_wstart + HB + 1;
    endfunction
    function automatic logic [31:0] expect_word(input logic [25:0] h);
        logic [25:0] r;
        r = h;
`ifdef MONOPIX_RO_GRAY_DEC_EN
        for (int i = 0; i < 8; i++) r[i] = ^(h[7:0] >> i);
`endif
        return {4'b0001, 2'b00, r};
    endfunction

    always @(posedge CLK) begin : model
        bit go, st, sh;
        int sz;
        go = TOKEN && ENABLE;
        st = m_store();
        sh = m_shift_idx() >= 0;
        if (RST) begin
            m_age = -1; m_unfrz = 0; m_q.delete(); m_lost = 0; m_bits = '0;
        end else begin
            sz = m_q.size();
            if (FIFO_READ && sz > 0) void'(m_q.pop_front());
            if (st) begin
                if (sz < DEPTH || FIFO_READ) m_q.push_back(expect_word(m_bits[25:0]));
                else if (m_lost < 255) m_lost++;
            end
            if (sh) m_bits = {m_bits[26:0], DATA};
            if (m_unfrz) begin
                m_age = -1; m_unfrz = 0;
            end else if (m_age < 0) begin
                if (go) begin m_age = 0; m_wstart = FD; m_started++; end
            end else if (st) begin
                if (go) begin m_age++; m_wstart = m_age; m_started++; end
                else m_unfrz = 1;
            end else begin
                m_age++;
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_on) begin
            chk("FREEZE", 32'(FREEZE), 32'(m_busy()));
            chk("READ", 32'(READ), 32'(m_read()));
            chk("SHIFT_EN", 32'(SHIFT_EN), 32'(m_shift_idx() >= 0));
            chk("FIFO_EMPTY", 32'(FIFO_EMPTY), 32'(m_q.size() == 0));
            chk("LOST_CNT", 32'(LOST_CNT), 32'(m_lost));
            if (m_q.size() > 0) chk("FIFO_DATA", FIFO_DATA, m_q[0]);
        end
    end

    // Advance one cycle; feed DATA MSB first for whichever shift cycle the timeline says comes next.
    task automatic step();
        int j;
        logic [25:0] w;
        @(posedge CLK);
        #1;
        j = m_shift_idx();
        if (j >= 0 && src_list.size() > 0) begin
            w    = src_list[(m_started - 1) % src_list.size()];
            DATA = w[HB-1-j];
        end else begin
            DATA = 1'b0;
        end
    endtask

    int r_reads[$];
    int r_shift_cnt, r_frz_cnt, r_frz_rise;

    // mode: 0 plain, 1 drop ENABLE at shift cycle 10, 2 RST at shift cycle 10, 3 FIFO_READ during STORE
    task automatic run(input int n, input int mode);
        int  k;
        bit  done;
        k = 0; done = 0;
        m_started = 0;
        r_reads.delete(); r_shift_cnt = 0; r_frz_cnt = 0; r_frz_rise = -1;
        ENABLE = 1; TOKEN = 1;
        while (!done) begin
            step();
            k++;
            TOKEN = (m_started < n);
            if (READ) r_reads.push_back(k);
            if (SHIFT_EN) r_shift_cnt++;
            if (FREEZE) begin
                r_frz_cnt++;
                if (r_frz_rise < 0) r_frz_rise = k;
            end
            FIFO_READ = (mode == 3) && m_store();
            if (mode == 1 && m_shift_idx() == 10) ENABLE = 0;
            if (mode == 2 && m_shift_idx() == 10) begin
                RST = 1; step(); RST = 0; done = 1;
            end
            if (m_age < 0 && k > 1) done = 1;
            if (k > 5000) begin
                checks++; errors++;
                $display("FAIL run_timeout: got %0d cycles expected idle", k);
                done = 1;
            end
        end
        TOKEN = 0; ENABLE = 1; FIFO_READ = 0;
    endtask

    task automatic pop_n(input int k);
        for (int i = 0; i < k; i++) begin
            FIFO_READ = 1; step(); FIFO_READ = 0;
        end
    endtask

    initial begin
        step(); cmp_on = 1; step(); step();
        RST = 0;
        chk("reset_empty", 32'(FIFO_EMPTY), 1);
        chk("reset_lost", 32'(LOST_CNT), 0);
        chk("reset_freeze", 32'(FREEZE), 0);

        src_list = '{26'h2AAAAAA};
        run(1, 0);
        chk("single_freeze_rise", r_frz_rise, 1);
        chk("single_nreads", r_reads.size(), 1);
        chk("single_read_cycle", (r_reads.size() > 0) ? r_reads[0] : -1, 1 + FD);
        chk("single_shift_cnt", r_shift_cnt, 26);
        chk("single_word", FIFO_DATA, W1);
        chk("single_freeze_low", 32'(FREEZE), 0);
        pop_n(1);
        chk("single_drained", 32'(FIFO_EMPTY), 1);

        src_list = '{26'h0000001, 26'h2000000, 26'h1234500};
        run(3, 0);
        chk("b2b_nreads", r_reads.size(), 3);
        if (r_reads.size() == 3) begin
            chk("b2b_gap1", r_reads[1] - r_reads[0], WPER);
            chk("b2b_gap2", r_reads[2] - r_reads[1], WPER);
        end
        chk("b2b_freeze_cycles", r_frz_cnt, FD + 3 * WPER);
        chk("b2b_w0", FIFO_DATA, 32'h10000001); pop_n(1);
        chk("b2b_w1", FIFO_DATA, 32'h12000000); pop_n(1);
        chk("b2b_w2", FIFO_DATA, 32'h11234500); pop_n(1);
        chk("b2b_drained", 32'(FIFO_EMPTY), 1);

        src_list.delete();
        for (int i = 0; i < 10; i++) src_list.push_back(26'(i << 8));
        run(10, 0);
        chk("ovf_lost", 32'(LOST_CNT), 2);
        chk("ovf_not_empty", 32'(FIFO_EMPTY), 0);
        for (int i = 0; i < 8; i++) begin
            chk("ovf_word", FIFO_DATA, 32'h10000000 | 32'(i << 8));
            pop_n(1);
        end
        chk("ovf_drained", 32'(FIFO_EMPTY), 1);

        src_list.delete();
        for (int i = 0; i < 8; i++) src_list.push_back(26'(i << 8));
        run(8, 0);
        chk("full_lost_before", 32'(LOST_CNT), 2);
        src_list = '{26'h00ABC00};
        run(1, 3);
        chk("fullpop_lost", 32'(LOST_CNT), 2);
        pop_n(7);
        chk("fullpop_count8", 32'(FIFO_EMPTY), 0);
        chk("fullpop_last", FIFO_DATA, 32'h100ABC00);
        pop_n(1);
        chk("fullpop_drained", 32'(FIFO_EMPTY), 1);

        src_list = '{26'h00000C0};
        run(1, 0);
        chk("gray_word", FIFO_DATA, WG);
        pop_n(1);

        src_list = '{26'h3FFFFFF};
        run(2, 1);
        chk("endrop_nreads", r_reads.size(), 1);
        chk("endrop_freeze_cycles", r_frz_cnt, FD + WPER);
        chk("endrop_word", FIFO_DATA, WF);
        chk("endrop_freeze_low", 32'(FREEZE), 0);

        src_list = '{26'h1555555};
        run(1, 2);
        chk("rst_freeze", 32'(FREEZE), 0);
        chk("rst_empty", 32'(FIFO_EMPTY), 1);
        chk("rst_lost", 32'(LOST_CNT), 0);

        step(); step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/monopix_ro_seq.md
MONOPIX_RO_SEQ -- requirements
Module: monopix_ro_seq

Interface
- REQ-001: Parameter HIT_BITS, default 26: number of serial bits per hit word shifted from the chip (legal range 8..28).
- REQ-002: Parameter FREEZE_DLY, default 2: cycles between FREEZE assertion and the first READ pulse (legal range 1..15).
- REQ-003: Parameter DEPTH_LOG2, default 3: log2 of output FIFO depth (8 words).
- REQ-004: Parameter DATA_IDENTIFIER, default 4'b0001: tag placed in FIFO_DATA[31:28].
- REQ-005: Port CLK, input, 1: the single clock; all logic SHALL be rising-edge on CLK.
- REQ-006: Port RST, input, 1: synchronous, active-high reset.
- REQ-007: Ports:
  - ENABLE, input, 1: permits starting a readout.
  - TOKEN, input, 1: chip hit-pending flag, already synchronous to CLK.
  - DATA, input, 1: chip serial data, sampled on CLK.
- REQ-008: Ports:
  - FREEZE, output, 1: freezes chip hit buffers.
  - READ, output, 1: loads the next hit into the chip shift register.
  - SHIFT_EN, output, 1: gates the chip output clock while bits are shifted.
- REQ-009: Ports:
  - FIFO_READ, input, 1
  - FIFO_EMPTY, output, 1
  - FIFO_DATA, output, 32
  - These SHALL form an arbiter-compatible first-word-fall-through source.
- REQ-010: Port LOST_CNT, output, 8: count of hit words dropped because the FIFO was full.

Function
- REQ-011: The FSM SHALL have the states IDLE, FRZ_WAIT, READ_P, SHIFT, STORE and UNFRZ.
- REQ-012: IDLE -> FRZ_WAIT when TOKEN=1 and ENABLE=1; otherwise it SHALL stay in IDLE with all strobes low.
- REQ-013: FREEZE SHALL be 1 in every state except IDLE and UNFRZ.
- REQ-014: FRZ_WAIT SHALL last exactly FREEZE_DLY cycles, then go to READ_P.
- REQ-015: READ_P SHALL last exactly 1 cycle with READ=1, then go to SHIFT.
- REQ-016: SHIFT SHALL last exactly HIT_BITS cycles with SHIFT_EN=1.
  - DATA is sampled every cycle, MSB first, into a HIT_BITS shift register.
- REQ-017: STORE SHALL last 1 cycle and push {DATA_IDENTIFIER, zero pad, hit[HIT_BITS-1:0]} into the FIFO.
  - Exit: READ_P if TOKEN=1 and ENABLE=1, else UNFRZ.
- REQ-018: UNFRZ SHALL last 1 cycle with FREEZE=0, then go to IDLE.
  - TOKEN is not re-evaluated until IDLE.
- REQ-019: Deasserting ENABLE mid-word SHALL NOT abort the word.
  - The current word completes through STORE, then UNFRZ.
- REQ-020: A push SHALL be accepted when the FIFO is not full, or when it is full and FIFO_READ=1 in the same cycle.
  - Otherwise the word SHALL be dropped and LOST_CNT incremented, saturating at 255.
- REQ-021: FIFO_DATA SHALL present the oldest word whenever FIFO_EMPTY=0.
  - FIFO_READ with FIFO_EMPTY=0 pops it; the next word, if any, appears the following cycle.
  - FIFO_READ while empty SHALL be ignored.
- REQ-022: Read and write pointers SHALL be DEPTH_LOG2+1 bits and wrap modulo 2*depth.
  - Full/empty are derived from pointer MSB comparison.
- REQ-023: Minimum cycles per hit word SHALL be HIT_BITS+2 for back-to-back hits (READ_P, SHIFT, STORE).

Reset
- REQ-024: On RST the following SHALL hold on the next CLK edge:
  - FSM in IDLE.
  - FREEZE=0, READ=0, SHIFT_EN=0.
  - FIFO pointers cleared, so FIFO_EMPTY=1.
  - LOST_CNT=0 and the shift register cleared.
- REQ-025: RST mid-readout SHALL discard the partial word and queued words, and drop FREEZE within one cycle.

Configuration
- REQ-026: Macro MONOPIX_RO_GRAY_DEC_EN, when defined, SHALL convert hit[7:0] (gray-coded timestamp) to binary before the STORE push.
  - When undefined, hit[7:0] SHALL be stored unmodified; all other behaviour is identical.

Verification
- REQ-027: Single hit.
  - Stimulus: ENABLE=1, TOKEN high for 1 cycle, DATA pattern 26'h2AAAAAA.
  - Required: FREEZE rises 1 cycle later; READ is high at cycle 1+FREEZE_DLY; 26 SHIFT_EN cycles; one FIFO word 32'h12AAAAAA; FREEZE low after UNFRZ.
- REQ-028: Back-to-back hits.
  - Stimulus: TOKEN held high for 3 words.
  - Required: FREEZE stays high continuously; READ pulses 28 cycles apart; 3 words queued in order.
- REQ-029: FIFO overflow.
  - Stimulus: 10 hits with FIFO_READ=0.
  - Required: 8 words stored; LOST_CNT=2; FIFO_EMPTY=0.
  - Then: 8 FIFO_READ pulses give FIFO_EMPTY=1.
- REQ-030: Full push plus pop.
  - Stimulus: STORE coincides with FIFO_READ=1 while the FIFO is full.
  - Required: word accepted; LOST_CNT unchanged; count stays 8.
- REQ-031: Disruption mid-SHIFT.
  - Stimulus: ENABLE dropped at shift cycle 10.
  - Required: word stored, then UNFRZ, then IDLE.
  - Stimulus: RST at shift cycle 10 instead.
  - Required: FREEZE=0 next cycle; FIFO_EMPTY=1; LOST_CNT=0.
- REQ-032: Gray decode, with MONOPIX_RO_GRAY_DEC_EN.
  - Stimulus: hit[7:0]=8'b11000000.
  - Required: stored 8'b10000000.
  - Without the macro: stored 8'b11000000.
